// File: rtl/handshakes_delay_valid_data.sv
// Single-entry forward register slice on a valid/ready stream: valid and data are
// registered, ready passes straight through. Define HSK_DELAY_ASSERT_EN for protocol checkers.
module handshakes_delay_valid_data #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  up_valid,
  input  logic [WORD_WIDTH-1:0] up_data,
  input  logic                  down_ready,
  output logic                  down_valid,
  output logic [WORD_WIDTH-1:0] down_data,
  output logic                  up_ready
);

  logic                  down_valid_q, down_valid_d;
  logic [WORD_WIDTH-1:0] down_data_q,  down_data_d;

  // The slice can take a beat when it is empty or its held beat leaves this cycle.
  assign up_ready   = down_ready | ~down_valid_q;
  assign down_valid = down_valid_q;
  assign down_data  = down_data_q;

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    down_valid_d = down_valid_q;
    down_data_d  = down_data_q;
    if (up_ready) begin
      down_valid_d = up_valid;
      if (up_valid) begin
        down_data_d = up_data;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      down_valid_q <= 1'b0;
      down_data_q  <= '0;
    end else begin
      down_valid_q <= down_valid_d;
      down_data_q  <= down_data_d;
    end
  end

`ifdef HSK_DELAY_ASSERT_EN
  // Previous-cycle snapshot used to detect changes on stalled interfaces.
  logic                  armed_q;
  logic                  up_valid_p, up_ready_p, down_valid_p, down_ready_p;
  logic [WORD_WIDTH-1:0] up_data_p, down_data_p;

  always_ff @(posedge clk) begin
    armed_q      <= rst_n;
    up_valid_p   <= up_valid;
    up_ready_p   <= up_ready;
    up_data_p    <= up_data;
    down_valid_p <= down_valid;
    down_ready_p <= down_ready;
    down_data_p  <= down_data;
  end

  always_ff @(posedge clk) begin
    if (rst_n && armed_q) begin
      if ($isunknown(down_valid) || $isunknown(up_ready)) begin
        $error("%0t: down_valid or up_ready is X/Z after reset", $time);
      end
      if (up_valid_p && !up_ready_p && (!up_valid || up_data != up_data_p)) begin
        $error("%0t: up_valid fell or up_data changed while up_ready=0", $time);
      end
      if (down_valid_p && !down_ready_p && (!down_valid || down_data != down_data_p)) begin
        $error("%0t: down_valid fell or down_data changed while down_ready=0", $time);
      end
    end
  end
`else
  // Checkers compiled out: the slice above is the complete design.
`endif

endmodule

// File: tb/tb_handshakes_delay_valid_data.sv
// Self-checking bench for handshakes_delay_valid_data: directed and random steps compared
// against a queue-based model of a depth-1 FIFO slice.
module tb_handshakes_delay_valid_data;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         up_valid;
  logic [W-1:0] up_data;
  logic         down_ready;
  logic         down_valid;
  logic [W-1:0] down_data;
  logic         up_ready;

  handshakes_delay_valid_data #(.WORD_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .down_ready (down_ready),
    .down_valid (down_valid),
    .down_data  (down_data),
    .up_ready   (up_ready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: the slice is a FIFO holding at most one beat; down_data shows the last beat stored.
  logic [W-1:0] model_q[$];
  logic [W-1:0] model_last = '0;
  logic [W-1:0] sent_q[$];
  logic [W-1:0] rcvd_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check up_ready, record handshakes, advance model, check outputs.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic rn,
                      input string tag);
    logic rdy;
    rst_n = rn; up_valid = v; up_data = d; down_ready = r;
    #1;
    rdy = (model_q.size() == 0) || r;
    chk({tag, ".up_ready"}, {31'd0, up_ready}, {31'd0, rdy});
    if (rn && down_valid === 1'b1 && r) rcvd_q.push_back(down_data);
    if (rn && v && rdy) sent_q.push_back(d);
    @(posedge clk);
    if (!rn) begin
      model_q.delete();
      model_last = '0;
    end else begin
      if (model_q.size() != 0 && r) void'(model_q.pop_front());
      if (rdy && v) begin
        model_q.push_back(d);
        model_last = d;
      end
    end
    #1;
    chk({tag, ".down_valid"}, {31'd0, down_valid}, {31'd0, model_q.size() != 0});
    chk({tag, ".down_data"}, {24'd0, down_data}, {24'd0, model_last});
  endtask

  initial begin
    logic         cur_v;
    logic [W-1:0] cur_d;
    logic         acc;

    rst_n = 1'b0; up_valid = 1'b1; up_data = 8'hAA; down_ready = 1'b0;
    @(posedge clk); #1;

    // Reset with a beat offered, then release: first edge latches AA.
    step(1'b1, 8'hAA, 1'b0, 1'b0, "reset");
    step(1'b1, 8'hAA, 1'b0, 1'b1, "reset_release");
    step(1'b0, 8'h00, 1'b1, 1'b1, "drain0");

    // Streaming at full throughput.
    for (int i = 1; i <= 16; i++) step(1'b1, W'(i), 1'b1, 1'b1, "stream");
    step(1'b0, 8'h00, 1'b1, 1'b1, "stream_drain");

    // Stall: hold 55 while 66 waits upstream.
    step(1'b1, 8'h55, 1'b1, 1'b1, "stall_load");
    for (int i = 0; i < 3; i++) step(1'b1, 8'h66, 1'b0, 1'b1, "stall_hold");
    step(1'b1, 8'h66, 1'b1, 1'b1, "stall_release");
    step(1'b0, 8'h00, 1'b1, 1'b1, "stall_drain");
    step(1'b0, 8'h00, 1'b1, 1'b1, "stall_empty");

    // Toggling ready with random traffic, each offer held until accepted.
    sent_q.delete();
    rcvd_q.delete();
    cur_v = 1'b0;
    cur_d = '0;
    for (int i = 0; i < 60; i++) begin
      if (!cur_v) begin
        cur_v = 1'($urandom_range(0, 1));
        cur_d = W'($urandom);
      end
      acc = cur_v && ((model_q.size() == 0) || i[0]);
      step(cur_v, cur_d, i[0], 1'b1, "toggle");
      if (acc) cur_v = 1'b0;
    end
    step(1'b0, 8'h00, 1'b1, 1'b1, "toggle_drain");
    step(1'b0, 8'h00, 1'b1, 1'b1, "toggle_drain");
    chk("toggle.count", rcvd_q.size(), sent_q.size());
    for (int i = 0; i < sent_q.size(); i++) begin
      if (i < rcvd_q.size()) chk("toggle.order", {24'd0, rcvd_q[i]}, {24'd0, sent_q[i]});
    end

    // Empty slice accepts while downstream is not ready.
    step(1'b1, 8'h3C, 1'b0, 1'b1, "empty_accept");
    step(1'b0, 8'h00, 1'b1, 1'b1, "empty_drain");
    step(1'b0, 8'h00, 1'b1, 1'b1, "empty_idle");

    // Reset while stalled discards the held beat.
    rcvd_q.delete();
    step(1'b1, 8'h77, 1'b1, 1'b1, "rst_stall_load");
    step(1'b0, 8'h00, 1'b0, 1'b1, "rst_stall_hold");
    step(1'b0, 8'h00, 1'b0, 1'b0, "rst_stall_reset");
    step(1'b0, 8'h00, 1'b1, 1'b1, "rst_stall_after");
    step(1'b0, 8'h00, 1'b1, 1'b1, "rst_stall_after");
    chk("rst_stall.delivered", rcvd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
